// File: rtl/clkgen_ctrl.sv
// Burst sequencer for a programmable toggling clock: N toggles of clk_out,
// H clk cycles apart, with abort and a one-cycle completion pulse.
module clkgen_ctrl #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned EDGE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  half_per,
    input  logic [EDGE_W-1:0] num_edges,
    input  logic              idle_lvl,
    input  logic              abort,
    output logic              clk_out,
    output logic              edge_stb,
    output logic              busy,
    output logic              done,
    output logic [EDGE_W-1:0] edge_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   timer_q,    timer_d;
    logic [CNT_W-1:0]   reload_q,   reload_d;
    logic [EDGE_W-1:0]  n_q,        n_d;
    logic               lvl_q,      lvl_d;
    logic               clk_out_q,  clk_out_d;
    logic               edge_stb_q, edge_stb_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [EDGE_W-1:0]  edge_cnt_q, edge_cnt_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            reload_q   <= '0;
            n_q        <= '0;
            lvl_q      <= 1'b0;
            clk_out_q  <= 1'b0;
            edge_stb_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            reload_q   <= reload_d;
            n_q        <= n_d;
            lvl_q      <= lvl_d;
            clk_out_q  <= clk_out_d;
            edge_stb_q <= edge_stb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    // Next-state and next-output logic; strobes default low every cycle
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        reload_d   = reload_q;
        n_d        = n_q;
        lvl_d      = lvl_q;
        clk_out_d  = clk_out_q;
        edge_stb_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        edge_cnt_d = edge_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Reload holds H-1, with a zero half period treated as one
                    reload_d   = (half_per == '0) ? '0 : half_per - CNT_W'(1);
                    timer_d    = reload_d;
                    n_d        = num_edges;
                    lvl_d      = idle_lvl;
                    clk_out_d  = idle_lvl;
                    edge_cnt_d = '0;
                    busy_d     = 1'b1;
                    if (num_edges == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    clk_out_d = lvl_q;
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                end else if (timer_q == '0) begin
                    clk_out_d  = ~clk_out_q;
                    edge_stb_d = 1'b1;
                    edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                    timer_d    = reload_q;
                    if (edge_cnt_d == n_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign clk_out  = clk_out_q;
    assign edge_stb = edge_stb_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Directed bench for clkgen_ctrl: bursts, H=0, N=0, abort, start re-pulse, mid-burst reset.
module tb_clkgen_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] half_per;
    logic [7:0] num_edges;
    logic       idle_lvl;
    logic       abort;
    logic       clk_out;
    logic       edge_stb;
    logic       busy;
    logic       done;
    logic [7:0] edge_cnt;

    int vectors;
    int miscompares;

    clkgen_ctrl #(.CNT_W(8), .EDGE_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .half_per  (half_per),
        .num_edges (num_edges),
        .idle_lvl  (idle_lvl),
        .abort     (abort),
        .clk_out   (clk_out),
        .edge_stb  (edge_stb),
        .busy      (busy),
        .done      (done),
        .edge_cnt  (edge_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full burst; noise keeps start high and scrambles the inputs until IDLE returns
    task automatic run_burst(input logic [7:0] h_raw, input int h, input int n,
                             input logic lvl, input bit noise);
        half_per  = h_raw;
        num_edges = 8'(n);
        idle_lvl  = lvl;
        start     = 1'b1;
        tick();
        if (!noise) start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_clk",  32'(clk_out), 32'(lvl));
        chk("start_cnt",  32'(edge_cnt), 32'd0);
        chk("start_done", 32'(done), 32'(n == 0));
        chk("start_stb",  32'(edge_stb), 32'd0);
        for (int c = 1; c <= n * h; c++) begin
            if (noise) begin
                half_per  = 8'($urandom_range(1, 9));
                num_edges = 8'($urandom_range(1, 9));
                idle_lvl  = ~idle_lvl;
            end
            tick();
            chk("run_clk",  32'(clk_out), 32'(lvl ^ 1'((c / h) % 2)));
            chk("run_stb",  32'(edge_stb), 32'(c % h == 0));
            chk("run_cnt",  32'(edge_cnt), 32'(c / h));
            chk("run_done", 32'(done), 32'(c == n * h));
            chk("run_busy", 32'(busy), 32'd1);
        end
        tick();
        start = 1'b0;
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(done), 32'd0);
        chk("end_stb",  32'(edge_stb), 32'd0);
        chk("end_clk",  32'(clk_out), 32'(lvl ^ 1'(n % 2)));
        chk("end_cnt",  32'(edge_cnt), 32'(n));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        half_per  = 8'd0;
        num_edges = 8'd0;
        idle_lvl  = 1'b0;
        abort     = 1'b0;

        #2;
        chk("rst_clk",  32'(clk_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stb",  32'(edge_stb), 32'd0);
        chk("rst_cnt",  32'(edge_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();

        // H=3, N=4, idle low
        run_burst(8'd3, 3, 4, 1'b0, 1'b0);

        // Abort ignored in IDLE
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_done", 32'(done), 32'd0);
        chk("idle_abort_cnt",  32'(edge_cnt), 32'd4);

        // H=0 behaves as H=1
        run_burst(8'd0, 1, 20, 1'b1, 1'b0);

        // N=0 completes immediately
        run_burst(8'd5, 5, 0, 1'b1, 1'b0);

        // Abort coinciding with the third toggle (H=4, N=10)
        half_per  = 8'd4;
        num_edges = 8'd10;
        idle_lvl  = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("ab_pre_cnt", 32'(edge_cnt), 32'd2);
        chk("ab_pre_clk", 32'(clk_out), 32'd1);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_clk",  32'(clk_out), 32'd1);
        chk("ab_done", 32'(done), 32'd1);
        chk("ab_stb",  32'(edge_stb), 32'd0);
        chk("ab_cnt",  32'(edge_cnt), 32'd2);
        chk("ab_busy", 32'(busy), 32'd1);
        tick();
        chk("ab_post_busy", 32'(busy), 32'd0);
        chk("ab_post_done", 32'(done), 32'd0);
        tick();
        chk("ab_once_done", 32'(done), 32'd0);
        chk("ab_hold_clk",  32'(clk_out), 32'd1);

        // start re-pulsed through RUN and DONE, then a fresh start is accepted
        run_burst(8'd2, 2, 5, 1'b0, 1'b1);
        run_burst(8'd1, 1, 3, 1'b1, 1'b0);

        // Reset mid-RUN while clk_out is high
        half_per  = 8'd2;
        num_edges = 8'd6;
        idle_lvl  = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("mr_pre_clk", 32'(clk_out), 32'd1);
        chk("mr_pre_stb", 32'(edge_stb), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_clk",  32'(clk_out), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_stb",  32'(edge_stb), 32'd0);
        chk("mr_cnt",  32'(edge_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_post_done", 32'(done), 32'd0);
        chk("mr_post_busy", 32'(busy), 32'd0);
        run_burst(8'd3, 3, 5, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
